// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core pipeline and the multiply/divide unit.
// The core drives the request side; the unit drives busy/done/result back.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // start is taken only while busy=0 and flush=0; done is a single-cycle
    // pulse during which result is the writeback value.
    modport master (
        output start, funct3, src_a, src_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, src_a, src_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up in a final cycle before the done pulse.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_unit_if.slave       i_bus,
    output logic [1:0]         o_state
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_t              r_state, w_next;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_neg;
    logic                r_a_neg;
    logic [XLEN-1:0]     r_result;

    logic                w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0]     w_a_abs, w_b_abs;
    logic                w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN:0]       w_mul_sum, w_div_cand, w_div_diff;
    logic [2*XLEN-1:0]   w_iter_acc, w_prod;
    logic [XLEN-1:0]     w_quo, w_rem, w_fix_res;

    // Operand conditioning at acceptance: MULHU/DIVU/REMU are fully unsigned,
    // MULHSU treats only rs1 as signed.
    always_comb begin
        w_accept   = (r_state == S_IDLE) && i_bus.start && !i_bus.flush;
        w_a_signed = (i_bus.funct3 != 3'b011) && (i_bus.funct3 != 3'b101) && (i_bus.funct3 != 3'b111);
        w_b_signed = w_a_signed && (i_bus.funct3 != 3'b010);
        w_a_neg    = w_a_signed && i_bus.src_a[XLEN-1];
        w_b_neg    = w_b_signed && i_bus.src_b[XLEN-1];
        w_a_abs    = w_a_neg ? -i_bus.src_a : i_bus.src_a;
        w_b_abs    = w_b_neg ? -i_bus.src_b : i_bus.src_b;
        w_div_zero = i_bus.funct3[2] && (i_bus.src_b == '0);
        w_div_ovf  = i_bus.funct3[2] && !i_bus.funct3[0] &&
                     (i_bus.src_a == MIN_NEG) && (i_bus.src_b == '1);
        w_special  = w_div_zero || w_div_ovf;
        if (w_div_zero) w_special_res = i_bus.funct3[1] ? i_bus.src_a : '1;
        else            w_special_res = i_bus.funct3[1] ? '0 : MIN_NEG;
    end

    // Multiply keeps {partial_hi, remaining_multiplier}; divide keeps
    // {partial_remainder, dividend_bits_then_quotient_bits}.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_div_cand = r_acc[2*XLEN-1:XLEN-1];
        w_div_diff = w_div_cand - {1'b0, r_b};
        if (!r_op[2])            w_iter_acc = {w_mul_sum, r_acc[XLEN-1:1]};
        else if (!w_div_diff[XLEN]) w_iter_acc = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        else                     w_iter_acc = {r_acc[2*XLEN-2:0], 1'b0};
    end

    always_comb begin
        w_prod = r_neg ? -r_acc : r_acc;
        w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem  = r_a_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        case (r_op)
            3'b000:                 w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_rem;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == LAST_CNT) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_bus.flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_a_neg  <= 1'b0;
            r_result <= '0;
        end else if (!i_bus.flush) begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op    <= i_bus.funct3;
                    r_b     <= w_b_abs;
                    r_acc   <= {{XLEN{1'b0}}, w_a_abs};
                    r_cnt   <= '0;
                    r_neg   <= w_a_neg ^ w_b_neg;
                    r_a_neg <= w_a_neg;
                    if (w_special) r_result <= w_special_res;
                end
                S_CALC: begin
                    r_acc <= w_iter_acc;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX:   r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign i_bus.busy   = (r_state != S_IDLE);
    assign i_bus.done   = (r_state == S_DONE) && !i_bus.flush;
    assign i_bus.result = r_result;
    assign o_state      = r_state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for each M-op and divide corner,
// plus hand sequences for ignored starts, flush and mid-operation reset.
module tb_muldiv_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    int         n_pass = 0;
    int         n_total = 0;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_bus   (bus.slave),
        .o_state (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Called at a negedge; drives start this cycle, then scrambles operands
    // after acceptance. Returns at the negedge of the cycle after done.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        bit seen;
        logic [31:0] res;
        bus.start = 1'b1; bus.funct3 = f3; bus.src_a = a; bus.src_b = b;
        cyc = 0; seen = 1'b0; res = '0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin seen = 1'b1; res = bus.result; end
            bus.start = 1'b0;
            bus.funct3 = 3'($urandom_range(0, 7));
            bus.src_a = $urandom; bus.src_b = $urandom;
        end
        check({name, " done_seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'(lat));
        check({name, " result"}, res, exp);
        @(negedge clk);
        check({name, " done_single"}, 32'(bus.done), 32'd0);
        check({name, " idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int dones;
        logic [31:0] res;

        vecs[0]  = '{"MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{"MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34};
        vecs[2]  = '{"MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[3]  = '{"MULHSU -1*2",     3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34};
        vecs[4]  = '{"DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
        vecs[5]  = '{"REM -7/2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
        vecs[6]  = '{"DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'd14,       34};
        vecs[7]  = '{"REMU 100/7",      3'b111, 32'd100,      32'd7,        32'd2,        34};
        vecs[8]  = '{"DIV 5/0",         3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{"REMU 5/0",        3'b111, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{"DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{"REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[12] = '{"DIVU 5/0",        3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[13] = '{"REM -5/0",        3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1};
        vecs[14] = '{"DIVU min/max",    3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34};
        vecs[15] = '{"REMU min/max",    3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
        vecs[16] = '{"DIV 7/-2",        3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        vecs[17] = '{"REM 7/-2",        3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34};
        vecs[18] = '{"DIV -7/-2",       3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        34};
        vecs[19] = '{"REM -7/-2",       3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 34};
        vecs[20] = '{"MUL x*16",        3'b000, 32'h12345678, 32'h10,       32'h23456780, 34};
        vecs[21] = '{"MULH x*16",       3'b001, 32'h12345678, 32'h10,       32'd1,        34};
        vecs[22] = '{"MULH -1*-1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        34};
        vecs[23] = '{"MUL -1*-1",       3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        34};
        vecs[24] = '{"MULHSU min*max",  3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
        vecs[25] = '{"MULHU min*2",     3'b011, 32'h80000000, 32'd2,        32'd1,        34};

        // Reset, then idle
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.src_a = '0; bus.src_b = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset state", 32'(state), 32'd0);

        for (int i = 0; i < 26; i++)
            run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Start mid-flight and start during the done cycle must both be ignored
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.src_a = 32'd100; bus.src_b = 32'd7;
        dones = 0; res = '0;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(negedge clk);
            if (bus.done) begin dones++; res = bus.result; end
            bus.start = 1'b0;
            if (cyc == 10 || cyc == 34) begin
                bus.start = 1'b1; bus.funct3 = 3'b000; bus.src_a = 32'd3; bus.src_b = 32'd3;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("hs done count", 32'(dones), 32'd1);
        check("hs result", res, 32'd14);
        check("hs start in done ignored", 32'(bus.busy), 32'd0);
        run_op("hs next MUL 3*4", 3'b000, 32'd3, 32'd4, 32'd12, 34);

        // Flush at CALC counter 15
        run_op("pre-flush DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 34);
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        dones = 0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            if (bus.done) dones++;
            bus.start = 1'b0;
            bus.flush = (cyc == 16);
            if (cyc == 17) begin
                check("flush busy", 32'(bus.busy), 32'd0);
                check("flush state", 32'(state), 32'd0);
                check("flush result kept", bus.result, 32'd14);
            end
        end
        check("flush no done", 32'(dones), 32'd0);

        // Flush and start together in IDLE: nothing accepted
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b000; bus.src_a = 32'd3; bus.src_b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush+start busy", 32'(bus.busy), 32'd0);
        run_op("post-flush MUL 3*4", 3'b000, 32'd3, 32'd4, 32'd12, 34);

        // Reset at CALC counter 20
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.src_a = 32'd9; bus.src_b = 32'd9;
        dones = 0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            if (bus.done) dones++;
            bus.start = 1'b0;
            rst = (cyc == 21);
            if (cyc == 22) begin
                check("rst busy", 32'(bus.busy), 32'd0);
                check("rst result", bus.result, 32'd0);
                check("rst state", 32'(state), 32'd0);
            end
        end
        check("rst no done", 32'(dones), 32'd0);
        run_op("post-rst MULHU", 3'b011, 32'h80000000, 32'd2, 32'd1, 34);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
